// File: rtl/udp_tx_pkg.sv
// Shared constants and types for the UDP transmit frame buffer.
// Optional feature macro: UDP_TX_FRAME_SEQ_EN (sequence tag in payload word 0).
package udp_tx_pkg;

  localparam int          UDP_HDR_BYTES = 8;
  localparam int          IP_HDR_BYTES  = 20;
  localparam logic [15:0] SEQ_TAG       = 16'hA55A;

  // Read-side FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } rd_state_e;

  // Word-index width for one bank; never below one bit.
  function automatic int idx_width(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/udp_tx_bank_ram.sv
// Simple dual-port payload RAM holding both ping-pong banks.
// Address is {bank, index}; synchronous write, registered read.
// Depth is rounded up to a power of two so {bank, index} always fits,
// which equals 2*PAYLOAD_WORDS whenever PAYLOAD_WORDS is a power of two.
module udp_tx_bank_ram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:(1<<AW)-1];
  logic [31:0] r_rdata;

  // Write port: one sample word per accepted write.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: registered output, one-cycle latency.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/udp_tx_frame_buffer.sv
// Ping-pong payload buffer feeding the UDP/IP transmit path (e_rxc domain).
// Samples fill two banks of PAYLOAD_WORDS words; a full bank is offered to
// the udp top via senden while the host capture command is high.
// Optional feature macro: UDP_TX_FRAME_SEQ_EN replaces payload word 0 on the
// read path with {16'hA55A, frame_cnt}.
//
// Handshake: a sample is transferred on every rising edge where
// sample_valid && sample_ready; sample_ready depends only on buffer state,
// never on sample_valid. A sample offered while sample_ready=0 is dropped
// and counted in drop_cnt.
module udp_tx_frame_buffer
  import udp_tx_pkg::*;
#(
  parameter int PAYLOAD_WORDS = 256,
  parameter int ADDR_W        = 12,
  parameter int DROP_CNT_W    = 16
) (
  input  logic                  e_rxc,
  input  logic                  reset_n,
  input  logic [31:0]           sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  sendcmd,
  input  logic                  sendstart,
  output logic                  senden,
  input  logic [ADDR_W-1:0]     ram_rd_addr,
  output logic [31:0]           ram_rd_data,
  output logic [15:0]           tx_data_length,
  output logic [15:0]           tx_total_length,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [15:0]           frame_cnt,
  output rd_state_e             o_dbg_state
);

  localparam int                IDX_W    = idx_width(PAYLOAD_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PAYLOAD_WORDS - 1);
  localparam logic [ADDR_W-1:0] WORDS_A  = ADDR_W'(PAYLOAD_WORDS);

  // Write side state
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic [IDX_W-1:0]      r_wr_ptr;
  // Read side state
  rd_state_e             r_state;
  logic                  r_rd_bank;
  logic                  r_rd_valid;
  logic                  r_rd_hit;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic [15:0]           r_frame_cnt;

  rd_state_e             w_state_nxt;
  logic                  w_senden;
  logic                  w_release;
  logic                  w_arm_enter;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_oth;
  logic                  w_other_free;
  logic                  w_pick;
  logic [1:0]            w_full_nxt;
  logic [31:0]           w_ram_q;

  assign sample_ready = !r_full[r_wr_bank];
  assign w_accept     = sample_valid && sample_ready;
  assign w_last       = (r_wr_ptr == LAST_IDX);
  assign w_oth        = ~r_wr_bank;
  // The other bank is usable if empty now or being released this cycle.
  assign w_other_free = !r_full[w_oth] || (w_release && (r_rd_bank == w_oth));
  // Oldest full bank: when both are full the write bank is the newer one.
  assign w_pick       = (&r_full) ? w_oth : r_full[1];

  // Bank occupancy: release by the read side, fill by the write side.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_accept && w_last) w_full_nxt[r_wr_bank] = 1'b1;
  end

  // Write pointer, write bank selection and occupancy flags.
  always_ff @(posedge e_rxc) begin
    if (!reset_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        if (w_last) begin
          r_wr_ptr <= '0;
          if (w_other_free) r_wr_bank <= w_oth;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end else if (r_full[r_wr_bank] && w_release && (r_rd_bank == w_oth)) begin
        // Stall recovery: move onto the bank the read side just freed.
        r_wr_bank <= w_oth;
      end
    end
  end

  // Saturating count of samples offered while the buffer was stalled.
  always_ff @(posedge e_rxc) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (sample_valid && !sample_ready && !(&r_drop_cnt)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Read FSM: state register and selected bank.
  always_ff @(posedge e_rxc) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rd_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arm_enter) r_rd_bank <= w_pick;
    end
  end

  // Read FSM: next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (sendcmd && (|r_full)) w_state_nxt = ARM;
      ARM: begin
        if (!sendcmd)       w_state_nxt = IDLE;
        else if (sendstart) w_state_nxt = SEND;
      end
      SEND:    if (!sendstart) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read FSM: outputs and single-cycle events.
  always_comb begin
    w_senden    = 1'b0;
    w_release   = 1'b0;
    w_arm_enter = 1'b0;
    case (r_state)
      IDLE:    w_arm_enter = sendcmd && (|r_full);
      ARM:     w_senden    = sendcmd;
      SEND:    w_release   = !sendstart;
      default: ;
    endcase
  end

  // Completed-frame counter, wraps naturally.
  always_ff @(posedge e_rxc) begin
    if (!reset_n) begin
      r_frame_cnt <= 16'd0;
    end else if (w_release) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Read gating: data stays zero until a frame is armed and for out-of-range addresses.
  always_ff @(posedge e_rxc) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
    end else begin
      if (w_arm_enter) r_rd_valid <= 1'b1;
      r_rd_hit <= r_rd_valid && (ram_rd_addr < WORDS_A);
    end
  end

  udp_tx_bank_ram #(
    .AW (IDX_W + 1)
  ) u_ram (
    .clk     (e_rxc),
    .i_we    (w_accept),
    .i_waddr ({r_wr_bank, r_wr_ptr}),
    .i_wdata (sample_data),
    .i_raddr ({r_rd_bank, ram_rd_addr[IDX_W-1:0]}),
    .o_rdata (w_ram_q)
  );

`ifdef UDP_TX_FRAME_SEQ_EN
  logic        r_seq_hit;
  logic [31:0] r_seq_word;

  // Sequence tag for word 0, captured alongside the RAM read.
  always_ff @(posedge e_rxc) begin
    if (!reset_n) begin
      r_seq_hit  <= 1'b0;
      r_seq_word <= 32'd0;
    end else begin
      r_seq_hit  <= (ram_rd_addr == '0);
      r_seq_word <= {SEQ_TAG, r_frame_cnt};
    end
  end

  assign ram_rd_data = !r_rd_hit ? 32'd0 : (r_seq_hit ? r_seq_word : w_ram_q);
`else
  assign ram_rd_data = r_rd_hit ? w_ram_q : 32'd0;
`endif

  assign senden          = w_senden;
  assign tx_data_length  = 16'(PAYLOAD_WORDS * 4 + UDP_HDR_BYTES);
  assign tx_total_length = 16'(PAYLOAD_WORDS * 4 + UDP_HDR_BYTES + IP_HDR_BYTES);
  assign drop_cnt        = r_drop_cnt;
  assign frame_cnt       = r_frame_cnt;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_udp_tx_frame_buffer.sv
// Directed testbench for udp_tx_frame_buffer (PAYLOAD_WORDS=4 instance plus a
// default-parameter instance). Builds with or without UDP_TX_FRAME_SEQ_EN.
module tb_udp_tx_frame_buffer;
  import udp_tx_pkg::*;

`ifdef UDP_TX_FRAME_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic e_rxc;
  logic reset_n;

  initial e_rxc = 1'b0;
  always #5 e_rxc = ~e_rxc;

  // ---------------- DUT (PAYLOAD_WORDS=4) ----------------
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        sendcmd;
  logic        sendstart;
  logic        senden;
  logic [11:0] ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic [15:0] drop_cnt;
  logic [15:0] frame_cnt;
  rd_state_e   dbg_state;

  udp_tx_frame_buffer #(
    .PAYLOAD_WORDS (4),
    .ADDR_W        (12),
    .DROP_CNT_W    (16)
  ) u_dut (
    .e_rxc           (e_rxc),
    .reset_n         (reset_n),
    .sample_data     (sample_data),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .sendcmd         (sendcmd),
    .sendstart       (sendstart),
    .senden          (senden),
    .ram_rd_addr     (ram_rd_addr),
    .ram_rd_data     (ram_rd_data),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .drop_cnt        (drop_cnt),
    .frame_cnt       (frame_cnt),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- DUT (default parameters) ----------------
  logic [11:0] def_addr;
  logic        def_ready;
  logic        def_senden;
  logic [31:0] def_rd_data;
  logic [15:0] def_data_len;
  logic [15:0] def_total_len;
  logic [15:0] def_drop_cnt;
  logic [15:0] def_frame_cnt;
  rd_state_e   def_state;

  udp_tx_frame_buffer u_dut_def (
    .e_rxc           (e_rxc),
    .reset_n         (reset_n),
    .sample_data     (32'h0),
    .sample_valid    (1'b0),
    .sample_ready    (def_ready),
    .sendcmd         (1'b0),
    .sendstart       (1'b0),
    .senden          (def_senden),
    .ram_rd_addr     (def_addr),
    .ram_rd_data     (def_rd_data),
    .tx_data_length  (def_data_len),
    .tx_total_length (def_total_len),
    .drop_cnt        (def_drop_cnt),
    .frame_cnt       (def_frame_cnt),
    .o_dbg_state     (def_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected payload word 0: sequence tag when enabled, otherwise the sample.
  function automatic logic [31:0] exp_w0(input logic [31:0] sample, input logic [15:0] fidx);
    return SEQ_EN ? {16'hA55A, fidx} : sample;
  endfunction

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge e_rxc);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    cyc();
    sample_valid = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    ram_rd_addr = a;
    cyc();
    chk(tag, ram_rd_data, exp);
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_senden"}, 32'(senden), 32'd0);
    chk({pfx, "_rd_data"}, ram_rd_data, 32'd0);
    chk({pfx, "_drop"}, 32'(drop_cnt), 32'd0);
    chk({pfx, "_frame"}, 32'(frame_cnt), 32'd0);
    chk({pfx, "_state"}, 32'(dbg_state), 32'(IDLE));
    chk({pfx, "_ready"}, 32'(sample_ready), 32'd1);
  endtask

  logic senden_seen;

  // ---------------- stimulus ----------------
  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    sample_data  = 32'h0;
    sample_valid = 1'b0;
    sendcmd      = 1'b0;
    sendstart    = 1'b0;
    ram_rd_addr  = 12'd0;
    def_addr     = 12'd300;
    senden_seen  = 1'b0;

    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();

    // Reset state and length constants
    check_reset_state("rst");
    chk("len_udp4", 32'(tx_data_length), 32'd24);
    chk("len_ip4", 32'(tx_total_length), 32'd44);
    chk("len_udp256", 32'(def_data_len), 32'd1032);
    chk("len_ip256", 32'(def_total_len), 32'd1052);
    chk("def_oob_rd", def_rd_data, 32'd0);

    // Test 1: one frame end to end
    sendcmd = 1'b1;
    push(32'd1);
    push(32'd2);
    push(32'd3);
    push(32'd4);
    chk("t1_senden_early", 32'(senden), 32'd0);
    cyc();
    chk("t1_senden_arm", 32'(senden), 32'd1);
    sendstart = 1'b1;
    cyc();
    chk("t1_senden_send", 32'(senden), 32'd0);
    rd(12'd0, exp_w0(32'd1, 16'd0), "t1_w0");
    rd(12'd1, 32'd2, "t1_w1");
    rd(12'd2, 32'd3, "t1_w2");
    rd(12'd3, 32'd4, "t1_w3");
    chk("t1_frame_mid", 32'(frame_cnt), 32'd0);
    repeat (5) cyc();
    sendstart = 1'b0;
    cyc();
    chk("t1_frame", 32'(frame_cnt), 32'd1);
    chk("t1_state", 32'(dbg_state), 32'(IDLE));
    cyc();
    chk("t1_senden_done", 32'(senden), 32'd0);

    // Test 2: no capture command, 12 samples into 8 words of storage
    sendcmd = 1'b0;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample_valid = 1'b1;
      sample_data  = 32'h100 + 32'(i);
      #1;
      chk("t2_ready", 32'(sample_ready), (i < 8) ? 32'd1 : 32'd0);
      if (senden) senden_seen = 1'b1;
      cyc();
    end
    sample_valid = 1'b0;
    chk("t2_drop", 32'(drop_cnt), 32'd4);
    chk("t2_senden_never", 32'(senden_seen), 32'd0);

    // Test 3: both banks full, send one, refill, next bank armed
    sendcmd = 1'b1;
    cyc();
    chk("t3_senden0", 32'(senden), 32'd1);
    sendstart = 1'b1;
    cyc();
    rd(12'd1, 32'h101, "t3_b0_w1");
    rd(12'd0, exp_w0(32'h100, 16'd0), "t3_b0_w0");
    sendstart = 1'b0;
    #1;
    chk("t3_ready_stalled", 32'(sample_ready), 32'd0);
    cyc();
    chk("t3_ready_rise", 32'(sample_ready), 32'd1);
    chk("t3_frame1", 32'(frame_cnt), 32'd1);
    push(32'h200);
    chk("t3_senden1", 32'(senden), 32'd1);
    push(32'h201);
    push(32'h202);
    push(32'h203);
    chk("t3_ready_full", 32'(sample_ready), 32'd0);
    sendstart = 1'b1;
    cyc();
    rd(12'd0, exp_w0(32'h104, 16'd1), "t3_b1_w0");
    rd(12'd2, 32'h106, "t3_b1_w2");
    sendstart = 1'b0;
    cyc();
    chk("t3_frame2", 32'(frame_cnt), 32'd2);
    cyc();
    chk("t3_senden2", 32'(senden), 32'd1);

    // Test 6: third frame, word 0 carries the sequence tag when enabled
    sendstart = 1'b1;
    cyc();
    rd(12'd0, exp_w0(32'h200, 16'd2), "t6_w0");
    rd(12'd1, 32'h201, "t6_w1");
    rd(12'd3, 32'h203, "t6_w3");
    rd(12'd4, 32'h0, "t3_oob");
    chk("t3_drop_kept", 32'(drop_cnt), 32'd4);

    // Test 5: reset during SEND
    chk("t5_in_send", 32'(dbg_state), 32'(SEND));
    reset_n = 1'b0;
    cyc();
    check_reset_state("t5");
    reset_n     = 1'b1;
    sendstart   = 1'b0;
    ram_rd_addr = 12'd1;
    cyc();
    chk("t5_gated_rd", ram_rd_data, 32'd0);
    push(32'h300);
    push(32'h301);
    push(32'h302);
    push(32'h303);
    cyc();
    chk("t5_senden", 32'(senden), 32'd1);
    sendstart = 1'b1;
    cyc();
    rd(12'd0, exp_w0(32'h300, 16'd0), "t5_w0");
    rd(12'd1, 32'h301, "t5_w1");
    sendstart = 1'b0;
    cyc();
    chk("t5_frame", 32'(frame_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
